// File: rtl/logic_eval_sched.sv
// Round-robin scheduler that shares one bit-serial evaluator y = (a & b) | (c ^ d) between two requesters.
// Optional parity output y_par is enabled by defining LOGIC_EVAL_PARITY_EN.
module logic_eval_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] c0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic [WIDTH-1:0] y
`ifdef LOGIC_EVAL_PARITY_EN
    ,
    output logic             y_par
`endif
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               rr_last_r;
    logic               owner_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_r, b_r, c_r, d_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   y_r;
    logic               gnt0_r, gnt1_r, done0_r, done1_r, busy_r;
    logic               grant_s;
    logic               win_s;
    logic               last_s;
    logic               run_last_s;
    logic               bit_s;
    logic [IDX_W-1:0]   idx_s;
    logic [WIDTH-1:0]   res_full_s;

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Next-state logic and arbitration; DONE may hand straight over to a waiting requester.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        win_s       = (req0 & req1) ? ~rr_last_r : req1;
        last_s      = (cnt_r == CNT_W'(WIDTH - 1));
        case (state_r)
            IDLE: begin
                if (req0 | req1) begin
                    grant_s     = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (req0 | req1) begin
                    grant_s     = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Serial datapath: one result bit per RUN cycle, LSB first.
    always_comb begin
        idx_s      = cnt_r[IDX_W-1:0];
        bit_s      = (a_r[idx_s] & b_r[idx_s]) | (c_r[idx_s] ^ d_r[idx_s]);
        res_full_s = res_r;
        res_full_s[idx_s] = bit_s;
        run_last_s = (state_r == RUN) & last_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, bit counter, result and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= 1'b1;
            owner_r   <= 1'b0;
            cnt_r     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            d_r       <= '0;
            res_r     <= '0;
            y_r       <= '0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            gnt0_r  <= grant_s & ~win_s;
            gnt1_r  <= grant_s & win_s;
            done0_r <= run_last_s & ~owner_r;
            done1_r <= run_last_s & owner_r;
            busy_r  <= (state_nxt_s != IDLE);
            if (grant_s) begin
                a_r       <= win_s ? a1 : a0;
                b_r       <= win_s ? b1 : b0;
                c_r       <= win_s ? c1 : c0;
                d_r       <= win_s ? d1 : d0;
                rr_last_r <= win_s;
                owner_r   <= win_s;
                cnt_r     <= '0;
                res_r     <= '0;
            end else if (state_r == RUN) begin
                res_r <= res_full_s;
                if (last_s) begin
                    cnt_r <= '0;
                    y_r   <= res_full_s;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    end

`ifdef LOGIC_EVAL_PARITY_EN
    logic y_par_r;

    // Parity tracks y and updates on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par_r <= 1'b0;
        end else if (run_last_s) begin
            y_par_r <= parity_f(res_full_s);
        end
    end

    assign y_par = y_par_r;
`endif

    assign gnt0  = gnt0_r;
    assign gnt1  = gnt1_r;
    assign done0 = done0_r;
    assign done1 = done1_r;
    assign busy  = busy_r;
    assign y     = y_r;

endmodule
